// File: rtl/pingpong_rd_ctrl_if.sv
// Output stream bundle of the ping-pong read controller.
// master drives data/valid/last; slave returns ready.
interface pingpong_rd_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/pingpong_rd_ctrl.sv
// Ping-pong read controller: drains two RAM banks in strict alternation
// (RAM1 first) into a ready/valid stream through a 2-entry output FIFO.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the expected bank to be pending; address 0 issues
//         | from here so back-to-back banks cost one idle stream cycle
//   READ  | issuing one read per cycle while the FIFO has room
//   FLUSH | last address issued; waiting for its word to land in the FIFO
module pingpong_rd_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int BANK_LEN = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              bank1_full,
    input  logic              bank2_full,
    output logic              bank1_free,
    output logic              bank2_free,
    output logic              ram1_rd_en,
    output logic [ADDR_W-1:0] ram1_rd_addr,
    input  logic [DATA_W-1:0] ram1_rd_data,
    output logic              ram2_rd_en,
    output logic [ADDR_W-1:0] ram2_rd_addr,
    input  logic [DATA_W-1:0] ram2_rd_data,
    pingpong_rd_ctrl_if.master dout_if,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_LEN - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic              pend1, pend2;
    logic              exp_bank;
    logic              pend_exp;
    logic              inflight, inflight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              push, pop, room, issue, issue_last, done;
    logic [DATA_W-1:0] cap_data;

    assign pend_exp   = exp_bank ? pend2 : pend1;
    assign pop        = (fifo_cnt != 2'd0) && dout_if.dout_ready;
    assign push       = inflight;
    // Occupancy counts the word still in flight from the RAM, so a read is
    // only issued when its data is guaranteed a FIFO slot.
    assign room       = (({1'b0, fifo_cnt} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;
    assign issue_last = (rd_addr == LAST_ADDR);
    assign done       = inflight && inflight_last;
    assign cap_data   = exp_bank ? ram2_rd_data : ram1_rd_data;

    assign ram1_rd_en   = issue && !exp_bank;
    assign ram2_rd_en   = issue && exp_bank;
    assign ram1_rd_addr = ram1_rd_en ? rd_addr : '0;
    assign ram2_rd_addr = ram2_rd_en ? rd_addr : '0;
    assign bank1_free   = done && !exp_bank;
    assign bank2_free   = done && exp_bank;

    assign dout_if.dout       = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr] : '0;
    assign dout_if.dout_last  = (fifo_cnt != 2'd0) && fifo_last[rd_ptr];
    assign dout_if.dout_valid = (fifo_cnt != 2'd0);

    // FSM state and read address register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            rd_addr <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
        end
    end

    // Next-state, read issue and address advance.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        issue       = 1'b0;
        case (state)
            IDLE:    issue = pend_exp && room;
            READ:    issue = room;
            FLUSH:   if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (issue) begin
            if (issue_last) begin
                state_nxt   = FLUSH;
                rd_addr_nxt = '0;
            end else begin
                state_nxt   = READ;
                rd_addr_nxt = rd_addr + ADDR_W'(1);
            end
        end
    end

    // Track the single outstanding RAM read and whether it is the bank's last.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;
        end
    end

    // Pending flags, alternation pointer and sticky overflow.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend1    <= 1'b0;
            pend2    <= 1'b0;
            exp_bank <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend1    <= pend1 ? !bank1_free : bank1_full;
            pend2    <= pend2 ? !bank2_free : bank2_full;
            exp_bank <= exp_bank ^ done;
            overflow <= overflow | (bank1_full && pend1) | (bank2_full && pend2);
        end
    end

    // Two-entry output FIFO; entries are tagged with the bank-last marker.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            fifo_last <= 2'b00;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= cap_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// Bench for pingpong_rd_ctrl with BANK_LEN=4, RAM1=A0..A3, RAM2=B0..B3.
module tb_pingpong_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int BL = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          bank1_full, bank2_full;
    logic          bank1_free, bank2_free;
    logic          ram1_rd_en, ram2_rd_en;
    logic [AW-1:0] ram1_rd_addr, ram2_rd_addr;
    logic [DW-1:0] ram1_rd_data, ram2_rd_data;
    logic          overflow;

    logic [DW-1:0] ram1 [BL];
    logic [DW-1:0] ram2 [BL];

    pingpong_rd_ctrl_if #(.DATA_W(DW)) dif ();

    pingpong_rd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BANK_LEN(BL)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .bank1_full   (bank1_full),
        .bank2_full   (bank2_full),
        .bank1_free   (bank1_free),
        .bank2_free   (bank2_free),
        .ram1_rd_en   (ram1_rd_en),
        .ram1_rd_addr (ram1_rd_addr),
        .ram1_rd_data (ram1_rd_data),
        .ram2_rd_en   (ram2_rd_en),
        .ram2_rd_addr (ram2_rd_addr),
        .ram2_rd_data (ram2_rd_data),
        .dout_if      (dif),
        .overflow     (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // RAM models: data valid the cycle after the read strobe.
    always @(posedge sys_clk) begin
        if (ram1_rd_en) ram1_rd_data <= ram1[ram1_rd_addr[1:0]];
        if (ram2_rd_en) ram2_rd_data <= ram2[ram2_rd_addr[1:0]];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Ready driver.
    int       rdy_mode = 0;
    int       rp = 0;
    logic [3:0] rpat = 4'b1001;
    initial begin
        dif.dout_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (rdy_mode == 0) dif.dout_ready = 1'b1;
            else dif.dout_ready = rpat[rp % 4];
            rp++;
        end
    end

    // Scoreboard and monitor.
    logic [8:0] exp_q[$];
    logic [8:0] held, got, want;
    bit         stall = 0;
    int         r1_next = 0, r2_next = 0;
    int         rd_cnt = 0, xfer_cnt = 0, free1 = 0, free2 = 0;
    bit         first_arm = 0;
    int         first_cyc = 0, last_cyc = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            stall   = 0;
            r1_next = 0;
            r2_next = 0;
        end else begin
            if (ram1_rd_en || ram2_rd_en) begin
                check(!(ram1_rd_en && ram2_rd_en), "rd_en_excl", {ram1_rd_en, ram2_rd_en}, 2'b01);
                rd_cnt++;
            end
            if (ram1_rd_en) begin
                check(ram1_rd_addr == AW'(r1_next), "rd1_addr", ram1_rd_addr, r1_next);
                r1_next = (r1_next + 1) % BL;
            end else if (ram1_rd_addr != '0) begin
                check(0, "rd1_addr_idle", ram1_rd_addr, 0);
            end
            if (ram2_rd_en) begin
                check(ram2_rd_addr == AW'(r2_next), "rd2_addr", ram2_rd_addr, r2_next);
                r2_next = (r2_next + 1) % BL;
            end else if (ram2_rd_addr != '0) begin
                check(0, "rd2_addr_idle", ram2_rd_addr, 0);
            end
            got = {dif.dout_last, dif.dout};
            if (stall) check(dif.dout_valid && got == held, "stall_hold", {dif.dout_valid, got}, {1'b1, held});
            if (dif.dout_valid && dif.dout_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_word", got, 0);
                end else begin
                    want = exp_q.pop_front();
                    check(got == want, "dout_word", got, want);
                end
                xfer_cnt++;
                if (first_arm) begin
                    first_cyc = cyc;
                    first_arm = 0;
                end
                last_cyc = cyc;
            end
            stall = dif.dout_valid && !dif.dout_ready;
            held  = got;
            if (bank1_free) free1++;
            if (bank2_free) free2++;
        end
    end

    function automatic logic [31:0] all_outs();
        return {1'b0, bank1_free, bank2_free, ram1_rd_en, ram1_rd_addr, ram2_rd_en, ram2_rd_addr,
                dif.dout, dif.dout_valid, dif.dout_last, overflow};
    endfunction

    task automatic push_bank(input int b);
        for (int i = 0; i < BL; i++)
            exp_q.push_back({i == BL - 1, (b == 1) ? DW'(8'hA0 + i) : DW'(8'hB0 + i)});
    endtask

    task automatic clear_counts();
        rd_cnt = 0; xfer_cnt = 0; free1 = 0; free2 = 0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; bank1_full = 1'b0; bank2_full = 1'b0;
        @(negedge sys_clk);
        check(all_outs() == 32'd0, "reset_outputs", all_outs(), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        exp_q.delete();
        clear_counts();
    endtask

    int t_pulse = 0;
    task automatic pulse(input logic b1, input logic b2);
        @(negedge sys_clk);
        bank1_full = b1; bank2_full = b2;
        t_pulse = cyc;
        @(negedge sys_clk);
        bank1_full = 1'b0; bank2_full = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dif.dout_valid) && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        check(n < 300, "drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        for (int i = 0; i < BL; i++) begin
            ram1[i] = DW'(8'hA0 + i);
            ram2[i] = DW'(8'hB0 + i);
        end
        sys_rst = 1'b1; bank1_full = 1'b0; bank2_full = 1'b0;
        repeat (2) @(negedge sys_clk);
        do_reset();

        // V1: single bank, latency and throughput
        push_bank(1);
        first_arm = 1;
        pulse(1, 0);
        drain();
        check(first_cyc - t_pulse == 3, "first_valid_latency", first_cyc - t_pulse, 3);
        check(last_cyc - first_cyc == 3, "throughput", last_cyc - first_cyc, 3);
        check(rd_cnt == 4, "v1_reads", rd_cnt, 4);
        check(free1 == 1 && free2 == 0, "v1_free", {free1[15:0], free2[15:0]}, 32'h0001_0000);

        // V2: both full together, RAM1 first
        do_reset();
        push_bank(1); push_bank(2);
        pulse(1, 1);
        drain();
        check(free1 == 1 && free2 == 1, "v2_free", {free1[15:0], free2[15:0]}, 32'h0001_0001);
        check(xfer_cnt == 8, "v2_words", xfer_cnt, 8);

        // V3: RAM2 first must wait for RAM1
        do_reset();
        pulse(0, 1);
        repeat (10) @(negedge sys_clk);
        check(rd_cnt == 0, "v3_no_reads", rd_cnt, 0);
        check(!dif.dout_valid, "v3_no_valid", dif.dout_valid, 0);
        push_bank(1); push_bank(2);
        pulse(1, 0);
        drain();
        check(free1 == 1 && free2 == 1, "v3_free", {free1[15:0], free2[15:0]}, 32'h0001_0001);

        // V4: ready toggling 1,0,0,1
        do_reset();
        rdy_mode = 1;
        push_bank(1);
        pulse(1, 0);
        drain();
        rdy_mode = 0;
        check(xfer_cnt == 4, "v4_words", xfer_cnt, 4);
        check(free1 == 1, "v4_free", free1, 1);

        // V5: overflow on re-full while reading
        do_reset();
        check(overflow == 1'b0, "v5_ovf_clear", overflow, 0);
        push_bank(1);
        pulse(1, 0);
        pulse(1, 0);
        @(negedge sys_clk);
        check(overflow == 1'b1, "v5_ovf_set", overflow, 1);
        drain();
        check(overflow == 1'b1, "v5_ovf_sticky", overflow, 1);
        check(rd_cnt == 4 && free1 == 1, "v5_stream", {rd_cnt[15:0], free1[15:0]}, 32'h0004_0001);

        // V6: reset mid-bank after A1 accepted
        do_reset();
        push_bank(1);
        pulse(1, 0);
        begin
            int n = 0;
            while (xfer_cnt < 2 && n < 50) begin
                @(negedge sys_clk);
                #1;
                n++;
            end
            check(n < 50, "v6_wait_timeout", xfer_cnt, 2);
        end
        sys_rst = 1'b1;
        exp_q.delete();
        @(negedge sys_clk);
        check(all_outs() == 32'd0, "v6_reset_outputs", all_outs(), 0);
        check(free1 == 0, "v6_no_free", free1, 0);
        #1;
        sys_rst = 1'b0;
        clear_counts();
        push_bank(1);
        pulse(1, 0);
        drain();
        check(xfer_cnt == 4 && free1 == 1, "v6_restart", {xfer_cnt[15:0], free1[15:0]}, 32'h0004_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
